// File: rtl/multi_early_debouncer_pkg.sv
// Shared types and default parameters for the multi-channel early-response debouncer.
package multi_early_debouncer_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int DEF_LOCKOUT_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES    = 2;

  function automatic logic is_lockout(input db_state_t s);
    return (s == WAIT1) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/early_db_channel.sv
// One debounced channel: input synchroniser, early-response FSM and lockout counter.
module early_db_channel
  import multi_early_debouncer_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db,
  output logic rise_tick,
  output logic fall_tick,
  output logic busy
);

  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sw_s;
  db_state_t              state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic                   db_r, db_s;
  logic                   rise_r, rise_s;
  logic                   fall_r, fall_s;
  logic                   busy_r;

  assign sw_s = sync_r[SYNC_STAGES-1];

  // Metastability synchroniser for the raw switch level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw};
    end
  end

  // Next-state logic: react on the first differing sample, then ignore the input during lockout.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    db_s    = db_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    case (state_r)
      ZERO: begin
        if (sw_s) begin
          state_s = WAIT1;
          db_s    = 1'b1;
          rise_s  = 1'b1;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ZERO;
        end
      end
      WAIT1: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_s = WAIT0;
          db_s    = 1'b0;
          fall_s  = 1'b1;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ONE;
        end
      end
      WAIT0: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ZERO;
        cnt_s   = CNT_ZERO;
        db_s    = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ZERO;
      cnt_r   <= CNT_ZERO;
      db_r    <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      db_r    <= db_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      busy_r  <= is_lockout(state_s);
    end
  end

  assign db        = db_r;
  assign rise_tick = rise_r;
  assign fall_tick = fall_r;
  assign busy      = busy_r;

endmodule

// File: rtl/multi_early_debouncer.sv
// N independent early-response switch debouncers sharing one clock and reset.
module multi_early_debouncer
  import multi_early_debouncer_pkg::*;
#(
  parameter int N              = 4,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] sw,
  output logic [N-1:0] db,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic [N-1:0] busy
);

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    early_db_channel #(
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (sw[ch]),
      .db        (db[ch]),
      .rise_tick (rise_tick[ch]),
      .fall_tick (fall_tick[ch]),
      .busy      (busy[ch])
    );
  end

endmodule
